// File: rtl/nabp_dual_port_ram_if.sv
// Bus bundle for the filtered-projection line store: per-port address,
// write strobe and data, plus the shared synchronous clear.
interface nabp_dual_port_ram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                         clear;
  logic                         we_0;
  logic                         we_1;
  logic        [ADDR_WIDTH-1:0] addr_0;
  logic        [ADDR_WIDTH-1:0] addr_1;
  logic        [DATA_WIDTH-1:0] data_in_0;
  logic        [DATA_WIDTH-1:0] data_in_1;
  logic signed [DATA_WIDTH-1:0] data_out_0;
  logic signed [DATA_WIDTH-1:0] data_out_1;

  modport master (
    output clear, we_0, we_1, addr_0, addr_1, data_in_0, data_in_1,
    input  data_out_0, data_out_1
  );

  modport slave (
    input  clear, we_0, we_1, addr_0, addr_1, data_in_0, data_in_1,
    output data_out_0, data_out_1
  );
endinterface

// File: rtl/nabp_dual_port_ram.sv
// True dual-port RAM, one clock, registered read-first outputs, whole-array
// synchronous clear. Port 0 wins when both ports write the same word.
module nabp_dpr_rd_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_q
);
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_q <= '0;
    else if (i_clear) r_q <= '0;
    else              r_q <= i_rdata;
  end

  assign o_q = r_q;
endmodule

module nabp_dual_port_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nabp_dual_port_ram_if.slave  bus
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]                 w_we;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_wdata;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_rdata;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_q;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign w_we    = {bus.we_1, bus.we_0};
  assign w_addr  = {bus.addr_1, bus.addr_0};
  assign w_wdata = {bus.data_in_1, bus.data_in_0};

  // Array has no reset; port 1 is applied first so a port 0 write to the
  // same word overrides it.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (bus.clear) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
        for (int p = NUM_PORTS-1; p >= 0; p--)
          if (w_we[p]) r_mem[w_addr[p]] <= w_wdata[p];
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_rdata[p] = r_mem[w_addr[p]];
    nabp_dpr_rd_reg #(.DATA_WIDTH(DATA_WIDTH)) u_rd (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clear (bus.clear),
      .i_rdata (w_rdata[p]),
      .o_q     (w_q[p])
    );
  end

  assign bus.data_out_0 = w_q[0];
  assign bus.data_out_1 = w_q[1];
endmodule

// File: tb/tb_nabp_dual_port_ram.sv
// Bench for nabp_dual_port_ram: directed vectors with literal expectations,
// plus a word-level memory model compared against both outputs every cycle.
module tb_nabp_dual_port_ram;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int N  = 256;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  nabp_dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  nabp_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: a word array with a "known" flag per word, and the value each
  // output must show after the latest edge.
  logic [DW-1:0] m_mem   [N];
  bit            m_known [N];
  logic [DW-1:0] m_q0, m_q1;
  bit            m_v0, m_v1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q0 = '0; m_q1 = '0; m_v0 = 1; m_v1 = 1;
    end else if (bus.clear) begin
      for (int i = 0; i < N; i++) begin m_mem[i] = '0; m_known[i] = 1; end
      m_q0 = '0; m_q1 = '0; m_v0 = 1; m_v1 = 1;
    end else begin
      m_q0 = m_mem[bus.addr_0]; m_v0 = m_known[bus.addr_0];
      m_q1 = m_mem[bus.addr_1]; m_v1 = m_known[bus.addr_1];
      if (bus.we_1) begin m_mem[bus.addr_1] = bus.data_in_1; m_known[bus.addr_1] = 1; end
      if (bus.we_0) begin m_mem[bus.addr_0] = bus.data_in_0; m_known[bus.addr_0] = 1; end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_v0) begin
      n_tests++;
      if (bus.data_out_0 !== m_q0) begin
        n_fail++;
        $display("FAIL model_q0 t=%0t got %h want %h", $time, bus.data_out_0, m_q0);
      end
    end
    if (m_v1) begin
      n_tests++;
      if (bus.data_out_1 !== m_q1) begin
        n_fail++;
        $display("FAIL model_q1 t=%0t got %h want %h", $time, bus.data_out_1, m_q1);
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.clear = 0; bus.we_0 = 0; bus.we_1 = 0;
    bus.data_in_0 = '0; bus.data_in_1 = '0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we_0 = 1; bus.addr_0 = a; bus.data_in_0 = d; tick(); bus.we_0 = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_known[i] = 0;
    reset_n = 0;
    idle(); bus.addr_0 = '0; bus.addr_1 = '0;
    #1;
    chk("reset_q0", bus.data_out_0, 16'h0000);
    chk("reset_q1", bus.data_out_1, 16'h0000);
    tick(); tick();
    reset_n = 1;

    // Async reset with outputs holding data; contents survive, writes under reset dropped.
    wr0(8'd50, 16'h00AA);
    wr0(8'd60, 16'h1234);
    bus.addr_0 = 8'd60; bus.addr_1 = 8'd60; tick();
    chk("pre_rst_q0", bus.data_out_0, 16'h1234);
    chk("pre_rst_q1", bus.data_out_1, 16'h1234);
    #2 reset_n = 0;
    #1;
    chk("async_rst_q0", bus.data_out_0, 16'h0000);
    chk("async_rst_q1", bus.data_out_1, 16'h0000);
    bus.we_0 = 1; bus.addr_0 = 8'd50; bus.data_in_0 = 16'hDEAD;
    tick();
    chk("hold_rst_q0", bus.data_out_0, 16'h0000);
    idle(); reset_n = 1;
    bus.addr_0 = 8'd50; tick();
    chk("survive_rst", bus.data_out_0, 16'h00AA);

    // Latency and signed data passthrough.
    wr0(8'd5, 16'h7FFF);
    bus.addr_0 = 8'd5; tick();
    chk("lat_7fff", bus.data_out_0, 16'h7FFF);
    bus.we_1 = 1; bus.addr_1 = 8'hFF; bus.data_in_1 = 16'h8001; tick(); bus.we_1 = 0;
    tick();
    chk("neg_8001_p1", bus.data_out_1, 16'h8001);

    // Fill i*3, then opposing sweeps.
    for (int i = 0; i < N; i++) wr0(AW'(i), DW'(i * 3));
    for (int i = 0; i < N; i++) begin
      bus.addr_0 = AW'(i); bus.addr_1 = AW'(N - 1 - i); tick();
      chk("sweep_q0", bus.data_out_0, DW'(i * 3));
      chk("sweep_q1", bus.data_out_1, DW'((N - 1 - i) * 3));
    end

    // Same-address dual write: port 0 wins.
    bus.we_0 = 1; bus.we_1 = 1; bus.addr_0 = 8'd10; bus.addr_1 = 8'd10;
    bus.data_in_0 = 16'h1111; bus.data_in_1 = 16'h2222; tick(); idle();
    tick();
    chk("collide_q0", bus.data_out_0, 16'h1111);
    chk("collide_q1", bus.data_out_1, 16'h1111);

    // Different-address dual write: both land.
    bus.we_0 = 1; bus.we_1 = 1; bus.addr_0 = 8'd100; bus.addr_1 = 8'd101;
    bus.data_in_0 = 16'h0A0A; bus.data_in_1 = 16'h0B0B; tick(); idle();
    tick();
    chk("dual_wr_q0", bus.data_out_0, 16'h0A0A);
    chk("dual_wr_q1", bus.data_out_1, 16'h0B0B);

    // Cross-port read during write returns old data (20*3 = 60).
    bus.we_0 = 1; bus.addr_0 = 8'd20; bus.data_in_0 = 16'h3333; bus.addr_1 = 8'd20; tick();
    chk("xport_old", bus.data_out_1, 16'd60);
    chk("rf_same_port_old", bus.data_out_0, 16'd60);
    idle(); tick();
    chk("xport_new", bus.data_out_1, 16'h3333);

    // Read-first on port 0.
    wr0(8'd7, 16'h0001);
    bus.we_0 = 1; bus.addr_0 = 8'd7; bus.data_in_0 = 16'h0002; tick();
    chk("rf_old", bus.data_out_0, 16'h0001);
    idle(); tick();
    chk("rf_new", bus.data_out_0, 16'h0002);

    // Clear beats a same-cycle write and zeroes every word.
    for (int i = 0; i < N; i++) wr0(AW'(i), DW'(i + 1));
    bus.addr_0 = 8'd3; bus.addr_1 = 8'd9; tick();
    chk("pre_clr_q1", bus.data_out_1, 16'd10);
    bus.clear = 1; bus.we_0 = 1; bus.data_in_0 = 16'h5555; tick();
    chk("clr_edge_q0", bus.data_out_0, 16'h0000);
    chk("clr_edge_q1", bus.data_out_1, 16'h0000);
    idle();
    for (int i = 0; i < N; i++) begin
      bus.addr_0 = AW'(i); bus.addr_1 = AW'(N - 1 - i); tick();
      chk("clr_sweep_q0", bus.data_out_0, 16'h0000);
      chk("clr_sweep_q1", bus.data_out_1, 16'h0000);
    end

    // Clear held several cycles with writes pending.
    wr0(8'd4, 16'h4444);
    bus.clear = 1; bus.we_1 = 1; bus.addr_1 = 8'd4; bus.data_in_1 = 16'h7777; bus.addr_0 = 8'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_hold_q0", bus.data_out_0, 16'h0000);
      chk("clr_hold_q1", bus.data_out_1, 16'h0000);
    end
    idle(); tick();
    chk("clr_hold_after", bus.data_out_0, 16'h0000);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nabp_dual_port_ram.md
Name: nabp_dual_port_ram

Overview:
Generic true dual-port RAM with two independent read/write ports, one clock, and registered (synchronous) read outputs. Used as the filtered-projection line store. Port 0 is filled by the host-side fill controller and read by processing swappable 0. Port 1 is read by processing swappable 1. A synchronous clear input zeroes the whole array.

Parameters:
DATA_WIDTH, 16, word width (kFilteredDataLength); data is two's-complement signed.
ADDR_WIDTH, 8, address width (kSLength).
DEPTH, 2**ADDR_WIDTH, number of words. Every address value is valid.

Ports:
clk  input  1  system clock; all state changes on its rising edge except reset.
reset_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous clear of the entire array.
we_0  input  1  port 0 write enable.
we_1  input  1  port 1 write enable.
addr_0  input  ADDR_WIDTH  port 0 address.
addr_1  input  ADDR_WIDTH  port 1 address.
data_in_0  input  DATA_WIDTH  port 0 write data.
data_in_1  input  DATA_WIDTH  port 1 write data.
data_out_0  output  DATA_WIDTH signed  port 0 registered read data.
data_out_1  output  DATA_WIDTH signed  port 1 registered read data.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array. It is not initialised by reset; contents are undefined until written or cleared.
- Reset (reset_n low, asynchronous): data_out_0 and data_out_1 go to 0 immediately and are held at 0 while reset_n is low. Array contents are unchanged. Writes and clear are ignored during reset.
- Read latency: one cycle. At edge N the port registers mem[addr_x] as sampled at edge N. The value is visible on data_out_x after edge N and holds until the next edge.
- Outputs update every cycle; there is no read enable.
- Write: if we_x is high at an edge, mem[addr_x] <= data_in_x.
- Read-during-write, same port and address: read-first. data_out_x shows the old contents; the new data is visible one cycle later.
- Cross-port, one port writes address A while the other reads A in the same cycle: the reader gets the old data.
- Simultaneous writes to the same address from both ports: port 0 wins; port 1's data is discarded.
- Simultaneous writes to different addresses: both complete.
- Clear (clear high at an edge, reset_n high):
  - all DEPTH words become 0 in that single edge;
  - both data_out registers load 0 on that edge;
  - clear has priority over we_0 and we_1, so writes in the same cycle are discarded.
- Clear held for several cycles: the array stays 0 and outputs stay 0.
- Reset asserted mid-operation: outputs go to 0 at once. The array keeps all values written before reset. A write at the same edge as the reset assertion is not performed.
- Address wrap: none needed. Every ADDR_WIDTH-bit value maps to a distinct word.
- Data passes through unmodified; no arithmetic and no sign extension.
- Usage note: a read-only port is tied off with we_x=0 and data_in_x=0. clear may be tied to 0 when every used word is always overwritten.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with outputs holding 0x1234 -> both outputs become 0 without waiting for a clock edge. Release reset, then read an address written earlier with 0x00AA -> returns 0x00AA, proving contents survived reset.
- Write/read latency: write 0x7FFF at address 5 on port 0, then present addr_0=5 with we_0=0 -> data_out_0=0x7FFF exactly one edge later. Negative value 0x8001 at address 0xFF reads back 0x8001 on port 1.
- Sequential fill then dual read:
  - write addr i with value i*3 for i=0..255 on port 0;
  - port 0 sweeps 0..255 ascending while port 1 sweeps 255..0 in the same cycles;
  - each output shows its value one cycle after its address.
- Collisions:
  - both ports write address 10 in the same cycle (0x1111 on port 0, 0x2222 on port 1) -> reads back 0x1111;
  - port 0 writes 0x3333 to address 20 while port 1 reads address 20 -> port 1 returns the old value, and 0x3333 on the next read.
- Read-first: address 7 holds 0x0001; write 0x0002 to it on port 0 with addr_0=7 -> data_out_0=0x0001 after that edge, 0x0002 after the following edge.
- Clear:
  - fill all words nonzero, then pulse clear for 1 cycle together with we_0=1, addr_0=3, data 0x5555;
  - both outputs are 0 on that edge;
  - a full sweep of all 256 addresses on both ports returns 0, including address 3.
